// File: rtl/uart_word_packer_if.sv
// uart_word_packer_if: byte stream in, masked FIFO words out, plus drop status
interface uart_word_packer_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int BYTES = DATA_WIDTH / 8;
    logic [7:0] rx_data;
    logic rx_valid;
    logic flush;
    logic full;
    logic w_en;
    logic [DATA_WIDTH-1:0] w_data;
    logic [BYTES-1:0] w_strb;
    logic overflow;
    logic [7:0] drop_cnt;
    modport master (
        output rx_data, rx_valid, flush, full,
        input w_en, w_data, w_strb, overflow, drop_cnt
    );
    modport slave (
        input rx_data, rx_valid, flush, full,
        output w_en, w_data, w_strb, overflow, drop_cnt
    );
endinterface

// File: rtl/uart_word_packer.sv
// uart_word_packer: packs UART bytes into byte-strobed FIFO words with idle/forced flush of partial words
module uart_word_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT = 64
) (
    input logic wclk,
    input logic wrst,
    uart_word_packer_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CW = $clog2(BYTES);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);
    typedef enum logic {EMPTY, HOLD} state_t;
    state_t state, state_nx;
    logic [BYTES-2:0][7:0] pk;
    logic [CW-1:0] cnt, cnt_nx;
    logic [TW-1:0] timer, timer_nx;
    logic flush_req;
    logic consume, free, at_last, full_load, flush_load, drop;
    logic [DATA_WIDTH-1:0] part_data;
    logic [BYTES-1:0] part_strb;
    assign consume = state == HOLD && !bus.full;
    assign free = state == EMPTY || consume;
    assign at_last = cnt == LAST;
    assign full_load = bus.rx_valid && at_last && free;
    assign drop = bus.rx_valid && at_last && !free;
    // a byte arriving this cycle defers any pending flush so it lands in the flushed word
    assign flush_load = flush_req && free && cnt != '0 && !bus.rx_valid;
    assign cnt_nx = (full_load || flush_load) ? '0 : (bus.rx_valid && !at_last) ? cnt + 1'b1 : cnt;
    assign timer_nx = (bus.rx_valid || cnt_nx == '0) ? '0 : (timer == TW'(TIMEOUT)) ? timer : timer + 1'b1;
    assign bus.w_en = state == HOLD;
    always_comb begin
        part_data = '0;
        part_strb = '0;
        for (int k = 0; k < BYTES - 1; k++) begin
            part_strb[k] = k < int'(cnt);
            part_data[8*k +: 8] = (k < int'(cnt)) ? pk[k] : 8'h00;
        end
    end
    always_comb begin
        state_nx = state;
        state_nx = (full_load || flush_load) ? HOLD : consume ? EMPTY : state;
    end
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) state <= EMPTY;
        else state <= state_nx;
    end
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            pk <= '0;
            cnt <= '0;
            timer <= '0;
            flush_req <= 1'b0;
            bus.w_data <= '0;
            bus.w_strb <= '0;
            bus.overflow <= 1'b0;
            bus.drop_cnt <= '0;
        end else begin
            if (bus.rx_valid && !at_last) pk[cnt] <= bus.rx_data;
            cnt <= cnt_nx;
            timer <= timer_nx;
            flush_req <= (flush_req || bus.flush || timer_nx == TW'(TIMEOUT)) && cnt_nx != '0;
            if (full_load) begin
                bus.w_data <= {bus.rx_data, pk};
                bus.w_strb <= '1;
            end else if (flush_load) begin
                bus.w_data <= part_data;
                bus.w_strb <= part_strb;
            end
            if (drop) bus.overflow <= 1'b1;
            if (drop && bus.drop_cnt != 8'hFF) bus.drop_cnt <= bus.drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_uart_word_packer.sv
// tb_uart_word_packer: directed table/sequence checks plus random traffic against a queue-based model
module tb_uart_word_packer;
    localparam int DW = 32;
    localparam int B = DW / 8;
    localparam int TO = 64;
    logic wclk;
    logic wrst;
    int checks = 0;
    int failures = 0;
    uart_word_packer_if #(.DATA_WIDTH(DW)) bus ();
    uart_word_packer #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (.wclk(wclk), .wrst(wrst), .bus(bus));
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;
    // reference model: packer is a byte queue, holding is a valid flag with its word
    logic [7:0] m_pq[$];
    bit m_hv;
    logic [DW-1:0] m_hd;
    logic [B-1:0] m_hs;
    bit m_req;
    int m_idle;
    bit m_ovf;
    int m_drops;
    task automatic model_reset();
        m_pq.delete();
        m_hv = 0;
        m_hd = '0;
        m_hs = '0;
        m_req = 0;
        m_idle = 0;
        m_ovf = 0;
        m_drops = 0;
    endtask
    task automatic load_word();
        m_hd = '0;
        m_hs = '0;
        foreach (m_pq[k]) begin
            m_hd[8*k +: 8] = m_pq[k];
            m_hs[k] = 1'b1;
        end
        m_pq.delete();
        m_hv = 1;
    endtask
    task automatic model(input logic v, input logic [7:0] d, input logic f, input logic fu);
        bit consumed;
        bit free;
        consumed = m_hv && !fu;
        free = !m_hv || consumed;
        if (consumed) m_hv = 0;
        if (v) begin
            m_idle = 0;
            if (m_pq.size() < B - 1) m_pq.push_back(d);
            else if (free) begin
                m_pq.push_back(d);
                load_word();
            end else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
        end else if (m_req && free && m_pq.size() > 0) load_word();
        if (m_pq.size() == 0) m_idle = 0;
        else if (!v && m_idle < TO) m_idle++;
        m_req = (m_req || f || m_idle == TO) && m_pq.size() > 0;
    endtask
    task automatic check_model(input string n);
        checks++;
        if (bus.w_en !== m_hv || (m_hv && (bus.w_data !== m_hd || bus.w_strb !== m_hs))
            || bus.overflow !== m_ovf || bus.drop_cnt !== 8'(m_drops)) begin
            failures++;
            $display("FAIL %s t=%0t got en=%b data=%h strb=%h ovf=%b drops=%0d want en=%b data=%h strb=%h ovf=%b drops=%0d",
                     n, $time, bus.w_en, bus.w_data, bus.w_strb, bus.overflow, bus.drop_cnt,
                     m_hv, m_hd, m_hs, m_ovf, m_drops);
        end
    endtask
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s t=%0t got=%h want=%h", n, $time, a, e);
        end
    endtask
    task automatic step(input logic v, input logic [7:0] d, input logic f, input logic fu);
        bus.rx_valid = v;
        bus.rx_data = d;
        bus.flush = f;
        bus.full = fu;
        @(posedge wclk);
        model(v, d, f, fu);
        #1;
        check_model("model");
    endtask
    task automatic chk_zero(input string n);
        chk({n, "_w_en"}, 64'(bus.w_en), 64'd0);
        chk({n, "_w_data"}, 64'(bus.w_data), 64'd0);
        chk({n, "_w_strb"}, 64'(bus.w_strb), 64'd0);
        chk({n, "_overflow"}, 64'(bus.overflow), 64'd0);
        chk({n, "_drop_cnt"}, 64'(bus.drop_cnt), 64'd0);
    endtask
    typedef struct {
        logic v;
        logic [7:0] d;
        logic f;
        logic fu;
        logic en;
        logic [DW-1:0] data;
        logic [B-1:0] strb;
    } vec_t;
    vec_t tbl[6];
    int rise;
    int highs;
    int rate;
    int frate;
    logic fu;
    initial begin
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0};
        tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 32'h44332211, 4'hF};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0};
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        bus.flush = 1'b0;
        bus.full = 1'b0;
        wrst = 1'b0;
        model_reset();
        repeat (2) @(posedge wclk);
        #1;
        chk_zero("reset");
        wrst = 1'b1;
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].fu);
            chk($sformatf("tbl%0d_en", i), 64'(bus.w_en), 64'(tbl[i].en));
            if (tbl[i].en) begin
                chk($sformatf("tbl%0d_data", i), 64'(bus.w_data), 64'(tbl[i].data));
                chk($sformatf("tbl%0d_strb", i), 64'(bus.w_strb), 64'(tbl[i].strb));
            end
        end
        step(1, 8'hA1, 0, 0);
        step(1, 8'hA2, 0, 0);
        rise = 0;
        for (int i = 1; i <= 80 && rise == 0; i++) begin
            step(0, 8'h00, 0, 0);
            if (bus.w_en) rise = i;
        end
        chk("timeout_rise", 64'(rise), 64'(TO + 1));
        chk("timeout_data", 64'(bus.w_data), 64'h0000A2A1);
        chk("timeout_strb", 64'(bus.w_strb), 64'h3);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 1, 0);
        highs = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 8'h00, 0, 0);
            highs += int'(bus.w_en);
        end
        chk("empty_flush_writes", 64'(highs), 64'd0);
        for (int i = 1; i <= 8; i++) begin
            step(1, 8'(i), 0, 1);
            if (i == 4) chk("stall_load_en", 64'(bus.w_en), 64'd1);
        end
        chk("stall_en", 64'(bus.w_en), 64'd1);
        chk("stall_data", 64'(bus.w_data), 64'h04030201);
        chk("stall_overflow", 64'(bus.overflow), 64'd1);
        chk("stall_drop_cnt", 64'(bus.drop_cnt), 64'd1);
        step(0, 8'h00, 0, 0);
        chk("release_en", 64'(bus.w_en), 64'd0);
        step(0, 8'h00, 1, 0);
        chk("flush_reg_cycle_en", 64'(bus.w_en), 64'd0);
        step(0, 8'h00, 0, 0);
        chk("kept_en", 64'(bus.w_en), 64'd1);
        chk("kept_data", 64'(bus.w_data), 64'h00070605);
        chk("kept_strb", 64'(bus.w_strb), 64'h7);
        step(0, 8'h00, 0, 0);
        for (int i = 1; i <= 4; i++) step(1, 8'hB0 + 8'(i), 0, 1);
        for (int i = 1; i <= 3; i++) step(1, 8'hC0 + 8'(i), 0, 1);
        chk("b2b_first_data", 64'(bus.w_data), 64'hB4B3B2B1);
        step(1, 8'hC4, 0, 0);
        chk("b2b_en", 64'(bus.w_en), 64'd1);
        chk("b2b_data", 64'(bus.w_data), 64'hC4C3C2C1);
        chk("b2b_strb", 64'(bus.w_strb), 64'hF);
        step(0, 8'h00, 0, 0);
        chk("b2b_done_en", 64'(bus.w_en), 64'd0);
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h5A, 1, 0);
        chk("same_cycle_en0", 64'(bus.w_en), 64'd0);
        step(0, 8'h00, 0, 0);
        chk("same_cycle_en", 64'(bus.w_en), 64'd1);
        chk("same_cycle_data", 64'(bus.w_data), 64'h005A2211);
        chk("same_cycle_strb", 64'(bus.w_strb), 64'h7);
        step(0, 8'h00, 0, 0);
        for (int i = 1; i <= 4; i++) step(1, 8'hD0 + 8'(i), 0, 1);
        chk("pre_reset_en", 64'(bus.w_en), 64'd1);
        #3;
        wrst = 1'b0;
        #1;
        chk_zero("async_reset");
        model_reset();
        @(posedge wclk);
        #1;
        wrst = 1'b1;
        for (int i = 1; i <= 4; i++) step(1, 8'hE0 + 8'(i), 0, 0);
        chk("post_reset_data", 64'(bus.w_data), 64'hE4E3E2E1);
        chk("post_reset_strb", 64'(bus.w_strb), 64'hF);
        fu = 1'b0;
        rate = 30;
        frate = 2;
        for (int i = 0; i < 6000; i++) begin
            if (i % 400 == 0) begin
                rate = int'($urandom_range(1, 70));
                frate = int'($urandom_range(0, 5));
            end
            if ($urandom_range(0, 11) == 0) fu = ~fu;
            step(int'($urandom_range(0, 99)) < rate, 8'($urandom), int'($urandom_range(0, 99)) < frate, fu);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
